hd44780_multi_timer: RTL and testbench

//  - Parametrised, multi-channel successor to the single-shot state timer.
//  - NCH independent down-count channels. Each channel has a one-shot or periodic mode,
//    a cancel input, a busy flag and an optional sticky done flag.
//  - Sits beside the HD44780 controller and nybble sender on the wishbone syscon clock/reset.
//  - Lets init delays, E-pulse timing and housekeeping blinks share one block.

---
 rtl/hd44780_multi_timer.sv | 137 +++++++++++++
 tb/tb_hd44780_multi_timer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_multi_timer.sv
// NCH independent down-count timers (one-shot or auto-reload) with cancel and busy flags.
// Optional sticky done flags are built only when H4_MULTI_TIMER_DONE_EN is defined.
module hd44780_multi_timer #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned TBITS = 23
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic [NCH*TBITS-1:0] DAT_I,
    input  logic [NCH-1:0]     start_strobe,
    input  logic [NCH-1:0]     stop_strobe,
    input  logic [NCH-1:0]     periodic,
    output logic [NCH-1:0]     end_strobe,
    output logic [NCH-1:0]     busy,
    output logic [NCH-1:0]     done,
    input  logic [NCH-1:0]     done_clr
);

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    state_e           state_q  [NCH];
    state_e           state_d  [NCH];
    logic [TBITS-1:0] count_q  [NCH];
    logic [TBITS-1:0] count_d  [NCH];
    logic [TBITS-1:0] reload_q [NCH];
    logic [TBITS-1:0] reload_d [NCH];
    logic [TBITS-1:0] load_val [NCH];
    logic [NCH-1:0]   mode_q, mode_d;
    logic [NCH-1:0]   end_q, end_d;
    logic [NCH-1:0]   expire;

    // A zero load value behaves as a one-cycle interval.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            load_val[c] = DAT_I[c*TBITS +: TBITS];
            if (load_val[c] == '0) begin
                load_val[c] = TBITS'(1);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            state_d[c]  = state_q[c];
            count_d[c]  = count_q[c];
            reload_d[c] = reload_q[c];
            mode_d[c]   = mode_q[c];
            end_d[c]    = 1'b0;
            expire[c]   = (state_q[c] == StRun) && (count_q[c] == TBITS'(1));

            unique case (state_q[c])
                StIdle: begin
                    if (start_strobe[c]) begin
                        state_d[c]  = StRun;
                        count_d[c]  = load_val[c];
                        reload_d[c] = load_val[c];
                        mode_d[c]   = periodic[c];
                    end
                end
                StRun: begin
                    if (start_strobe[c]) begin
                        // Restart discards the old count but keeps an expiry due on this edge.
                        end_d[c]    = expire[c];
                        count_d[c]  = load_val[c];
                        reload_d[c] = load_val[c];
                        mode_d[c]   = periodic[c];
                    end else if (stop_strobe[c]) begin
                        state_d[c] = StIdle;
                        count_d[c] = '0;
                    end else if (expire[c]) begin
                        end_d[c] = 1'b1;
                        if (mode_q[c]) begin
                            count_d[c] = reload_q[c];
                        end else begin
                            state_d[c] = StIdle;
                            count_d[c] = '0;
                        end
                    end else begin
                        count_d[c] = count_q[c] - TBITS'(1);
                    end
                end
                default: state_d[c] = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]  <= StIdle;
                count_q[c]  <= '0;
                reload_q[c] <= '0;
            end
            mode_q <= '0;
            end_q  <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]  <= state_d[c];
                count_q[c]  <= count_d[c];
                reload_q[c] <= reload_d[c];
            end
            mode_q <= mode_d;
            end_q  <= end_d;
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            busy[c] = (state_q[c] == StRun);
        end
    end

    assign end_strobe = end_q;

`ifdef H4_MULTI_TIMER_DONE_EN
    logic [NCH-1:0] done_q;

    // Set takes priority over a same-edge clear.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            done_q <= '0;
        end else begin
            done_q <= (done_q & ~done_clr) | end_d;
        end
    end

    assign done = done_q;
`else
    logic unused_done_clr;
    assign unused_done_clr = ^done_clr;
    assign done            = '0;
`endif

endmodule

// File: tb/tb_hd44780_multi_timer.sv
// Directed bench for hd44780_multi_timer: one task per scenario, inline comparisons.
module tb_hd44780_multi_timer;

    localparam int unsigned NCH = 4;
    localparam int unsigned TBITS = 23;
`ifdef H4_MULTI_TIMER_DONE_EN
    localparam bit DoneEn = 1'b1;
`else
    localparam bit DoneEn = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [NCH*TBITS-1:0] dat;
    logic [NCH-1:0]       start_s, stop_s, per, done_clr;
    logic [NCH-1:0]       end_s, busy, done;

    int n_vec;
    int n_err;

    hd44780_multi_timer #(
        .NCH   (NCH),
        .TBITS (TBITS)
    ) dut (
        .CLK_I        (clk),
        .RST_I        (rst_n),
        .DAT_I        (dat),
        .start_strobe (start_s),
        .stop_strobe  (stop_s),
        .periodic     (per),
        .end_strobe   (end_s),
        .busy         (busy),
        .done         (done),
        .done_clr     (done_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dat(input int ch, input int val);
        dat[ch*TBITS +: TBITS] = TBITS'(val);
    endtask

    // Drives a start on channel ch; the following tick() is edge k.
    task automatic arm(input int ch, input int val, input bit p);
        set_dat(ch, val);
        per[ch]     = p;
        start_s[ch] = 1'b1;
        tick();
        start_s[ch] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_s = '1;
        set_dat(0, 3);
        tick();
        tick();
        start_s = '0;
        if (end_s !== 4'b0000 || busy !== 4'b0000 || done !== 4'b0000) begin
            $display("FAIL reset end=%b busy=%b done=%b required 0000/0000/0000", end_s, busy, done);
            n_err++;
        end
        n_vec++;
        rst_n = 1'b1;
        tick();
        if (busy !== 4'b0000) begin
            $display("FAIL reset_release busy=%b required 0000", busy);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_oneshot();
        logic [NCH-1:0] ee, eb;
        arm(0, 114, 1'b0);
        if (busy !== 4'b0001 || end_s !== 4'b0000) begin
            $display("FAIL oneshot_start busy=%b end=%b required 0001/0000", busy, end_s);
            n_err++;
        end
        n_vec++;
        for (int j = 1; j <= 116; j++) begin
            tick();
            ee = (j == 114) ? 4'b0001 : 4'b0000;
            eb = (j < 114) ? 4'b0001 : 4'b0000;
            if (end_s !== ee || busy !== eb) begin
                $display("FAIL oneshot k+%0d end=%b busy=%b required %b/%b", j, end_s, busy, ee, eb);
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_periodic_stop();
        logic [NCH-1:0] ee, eb;
        arm(1, 3, 1'b1);
        set_dat(1, 7);  // must not affect the running channel
        for (int j = 1; j <= 13; j++) begin
            tick();
            stop_s[1] = 1'b0;
            ee = (j == 3 || j == 6 || j == 9) ? 4'b0010 : 4'b0000;
            eb = (j < 10) ? 4'b0010 : 4'b0000;
            if (end_s !== ee || busy !== eb) begin
                $display("FAIL periodic k+%0d end=%b busy=%b required %b/%b", j, end_s, busy, ee, eb);
                n_err++;
            end
            n_vec++;
            if (j == 9) stop_s[1] = 1'b1;
        end
        per[1] = 1'b0;
    endtask

    task automatic test_restart();
        logic [NCH-1:0] ee, eb;
        arm(2, 50, 1'b0);
        for (int j = 1; j <= 55; j++) begin
            tick();
            start_s[2] = 1'b0;
            ee = (j == 30) ? 4'b0100 : 4'b0000;
            eb = (j < 30) ? 4'b0100 : 4'b0000;
            if (end_s !== ee || busy !== eb) begin
                $display("FAIL restart k+%0d end=%b busy=%b required %b/%b", j, end_s, busy, ee, eb);
                n_err++;
            end
            n_vec++;
            if (j == 19) begin
                set_dat(2, 10);
                start_s[2] = 1'b1;
            end
        end
    endtask

    task automatic test_zero_and_start_stop();
        arm(3, 0, 1'b0);
        if (end_s !== 4'b0000 || busy !== 4'b1000) begin
            $display("FAIL zero_k end=%b busy=%b required 0000/1000", end_s, busy);
            n_err++;
        end
        n_vec++;
        tick();
        if (end_s !== 4'b1000 || busy !== 4'b0000) begin
            $display("FAIL zero_k+1 end=%b busy=%b required 1000/0000", end_s, busy);
            n_err++;
        end
        n_vec++;
        stop_s[3] = 1'b1;
        arm(3, 2, 1'b0);
        stop_s[3] = 1'b0;
        if (busy !== 4'b1000 || end_s !== 4'b0000) begin
            $display("FAIL startstop_k busy=%b end=%b required 1000/0000", busy, end_s);
            n_err++;
        end
        n_vec++;
        tick();
        tick();
        if (end_s !== 4'b1000 || busy !== 4'b0000) begin
            $display("FAIL startstop_k+2 end=%b busy=%b required 1000/0000", end_s, busy);
            n_err++;
        end
        n_vec++;
        // Stop on an idle channel does nothing.
        stop_s[3] = 1'b1;
        tick();
        stop_s[3] = 1'b0;
        tick();
        if (end_s !== 4'b0000 || busy !== 4'b0000) begin
            $display("FAIL stop_idle end=%b busy=%b required 0000/0000", end_s, busy);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_reset_midcount();
        logic [NCH-1:0] eb;
        arm(0, 40, 1'b0);
        for (int j = 1; j <= 45; j++) begin
            tick();
            eb = (j < 20) ? 4'b0001 : 4'b0000;
            if (end_s !== 4'b0000 || busy !== eb || (j >= 20 && done !== 4'b0000)) begin
                $display("FAIL rst_mid k+%0d end=%b busy=%b done=%b required 0000/%b", j, end_s,
                         busy, done, eb);
                n_err++;
            end
            n_vec++;
            if (j == 19) rst_n = 1'b0;
            if (j == 21) rst_n = 1'b1;
        end
        arm(0, 4, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (end_s !== ((j == 4) ? 4'b0001 : 4'b0000)) begin
                $display("FAIL rst_after k+%0d end=%b required %b", j, end_s,
                         (j == 4) ? 4'b0001 : 4'b0000);
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_done();
        logic [NCH-1:0] ed;
        arm(1, 5, 1'b0);
        for (int j = 1; j <= 12; j++) begin
            tick();
            done_clr[1] = 1'b0;
            ed = (DoneEn && j >= 5 && j < 9) ? 4'b0010 : 4'b0000;
            if (done !== ed) begin
                $display("FAIL done k+%0d done=%b required %b", j, done, ed);
                n_err++;
            end
            n_vec++;
            if (j == 8) done_clr[1] = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        logic [NCH-1:0] ee;
        set_dat(0, 2);
        set_dat(1, 4);
        set_dat(2, 2);
        per     = 4'b0100;
        start_s = 4'b0111;
        tick();
        start_s = '0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            ee = 4'b0000;
            if (j == 2) ee = 4'b0101;
            if (j == 4) ee = 4'b0110;
            if (j == 6) ee = 4'b0100;
            if (end_s !== ee) begin
                $display("FAIL b2b k+%0d end=%b required %b", j, end_s, ee);
                n_err++;
            end
            n_vec++;
        end
        stop_s = 4'b0100;
        tick();
        stop_s = '0;
        per    = '0;
        if (busy !== 4'b0000) begin
            $display("FAIL b2b_stop busy=%b required 0000", busy);
            n_err++;
        end
        n_vec++;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        dat      = '0;
        start_s  = '0;
        stop_s   = '0;
        per      = '0;
        done_clr = '0;
        test_reset();
        test_oneshot();
        test_periodic_stop();
        test_restart();
        test_zero_and_start_stop();
        test_reset_midcount();
        test_done();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
